// File: rtl/scoreboard_pkg.sv
// rtl/scoreboard_pkg.sv - shared constants and types for the scoreboard display mux
//
// Purpose: 7-segment patterns (active-low {g,f,e,d,c,b,a}), digit-index
// constants for the 4-digit scan, the snapshot record, and parameter defaults.
// Ports: none (package).

package scoreboard_pkg;

  localparam int REFRESH_DIV_DEFAULT  = 50000;
  localparam int FLASH_FRAMES_DEFAULT = 32;

  typedef logic [1:0] digit_idx_t;

  localparam digit_idx_t DIG_S2_ONES = 2'd0;
  localparam digit_idx_t DIG_S2_TENS = 2'd1;
  localparam digit_idx_t DIG_S1_ONES = 2'd2;
  localparam digit_idx_t DIG_S1_TENS = 2'd3;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Frame-stable copy of the scoring block's outputs.
  typedef struct packed {
    logic [3:0] s1_tens;
    logic [3:0] s1_ones;
    logic [3:0] s2_tens;
    logic [3:0] s2_ones;
    logic       possession;
  } snapshot_t;

  // Active-low one-hot digit enable for a scan index.
  function automatic logic [3:0] anode_for(input digit_idx_t idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/scoreboard_display_mux_encoder.sv
// rtl/scoreboard_display_mux_encoder.sv - BCD value to active-low 7-segment pattern
//
// Purpose: combinational encoder; values 10..15 show a dash, blank forces all
// segments off.
// Ports:
//   value  in  4  digit value
//   blank  in  1  1 = all segments off
//   seg    out 7  active-low {g,f,e,d,c,b,a}

module seven_seg_encoder
  import scoreboard_pkg::*;
(
  input  logic [3:0] value,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    if (blank) begin
      seg = SEG_BLANK;
    end else begin
      case (value)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_DASH;
      endcase
    end
  end

endmodule

// File: rtl/scoreboard_display_mux.sv
// rtl/scoreboard_display_mux.sv - 4-digit multiplexed 7-segment scoreboard driver
//
// Purpose: scans one digit per REFRESH_DIV-cycle slot, snapshots scores and
// possession once per frame (on the 3->0 index wrap) so a frame never tears,
// and drives registered active-low anode/seg/dp.
// Optional feature macro: SCOREBOARD_FLASH_EN (flash a team's digits for
// FLASH_FRAMES frames after its score changes).
// Ports:
//   clock       in  1  system clock
//   reset       in  1  synchronous active-high reset
//   possession  in  1  0 = team 1 has the ball, 1 = team 2
//   score1tens  in  4  team 1 tens (BCD)
//   score1ones  in  4  team 1 ones (BCD)
//   score2tens  in  4  team 2 tens (BCD)
//   score2ones  in  4  team 2 ones (BCD)
//   anode       out 4  digit enables, active-low, bit n = digit n
//   seg         out 7  segments, active-low {g,f,e,d,c,b,a}
//   dp          out 1  decimal point, active-low

module scoreboard_display_mux
  import scoreboard_pkg::*;
#(
  parameter int REFRESH_DIV  = REFRESH_DIV_DEFAULT,
  parameter int FLASH_FRAMES = FLASH_FRAMES_DEFAULT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       possession,
  input  logic [3:0] score1tens,
  input  logic [3:0] score1ones,
  input  logic [3:0] score2tens,
  input  logic [3:0] score2ones,
  output logic [3:0] anode,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

  logic [CNT_W-1:0] refresh_cnt;
  digit_idx_t       digit_idx;
  snapshot_t        snap;
  snapshot_t        snap_next;
  logic             slot_end;
  logic             frame_end;
  logic             team1_hide;
  logic             team2_hide;
  logic [3:0]       cur_val;
  logic             cur_blank;
  logic [6:0]       seg_next;
  logic             dp_next;

  assign slot_end  = (refresh_cnt == CNT_W'(REFRESH_DIV - 1));
  assign frame_end = slot_end && (digit_idx == DIG_S1_TENS);
  assign snap_next = {score1tens, score1ones, score2tens, score2ones, possession};

  always_ff @(posedge clock) begin
    if (reset) begin
      refresh_cnt <= '0;
      digit_idx   <= DIG_S2_ONES;
      snap        <= '0;
    end else begin
      if (slot_end) begin
        refresh_cnt <= '0;
        digit_idx   <= digit_idx + 2'd1;
      end else begin
        refresh_cnt <= refresh_cnt + 1'b1;
      end
      if (frame_end) begin
        snap <= snap_next;
      end
    end
  end

`ifdef SCOREBOARD_FLASH_EN
  localparam int FLASH_W = $clog2(FLASH_FRAMES + 1);

  logic [FLASH_W-1:0] flash1_cnt;
  logic [FLASH_W-1:0] flash2_cnt;

  // Counters move only at snapshots, so they count frames. A change compares
  // the incoming score against the snapshot being replaced.
  always_ff @(posedge clock) begin
    if (reset) begin
      flash1_cnt <= '0;
      flash2_cnt <= '0;
    end else if (frame_end) begin
      if ({score1tens, score1ones} != {snap.s1_tens, snap.s1_ones}) begin
        flash1_cnt <= FLASH_W'(FLASH_FRAMES);
      end else if (flash1_cnt != '0) begin
        flash1_cnt <= flash1_cnt - 1'b1;
      end
      if ({score2tens, score2ones} != {snap.s2_tens, snap.s2_ones}) begin
        flash2_cnt <= FLASH_W'(FLASH_FRAMES);
      end else if (flash2_cnt != '0) begin
        flash2_cnt <= flash2_cnt - 1'b1;
      end
    end
  end

  // Odd counts blank, so a flashing team alternates off/on frame by frame.
  assign team1_hide = (flash1_cnt != '0) && flash1_cnt[0];
  assign team2_hide = (flash2_cnt != '0) && flash2_cnt[0];
`else
  // Flashing compiled out: digits are always shown and FLASH_FRAMES is inert.
  assign team1_hide = (FLASH_FRAMES < 0);
  assign team2_hide = team1_hide;
`endif

  // Pick the snapshot digit for the current scan slot; tens digits of 0 blank.
  always_comb begin
    cur_val   = snap.s2_ones;
    cur_blank = 1'b0;
    case (digit_idx)
      DIG_S2_ONES: begin
        cur_val   = snap.s2_ones;
        cur_blank = team2_hide;
      end
      DIG_S2_TENS: begin
        cur_val   = snap.s2_tens;
        cur_blank = team2_hide || (snap.s2_tens == 4'd0);
      end
      DIG_S1_ONES: begin
        cur_val   = snap.s1_ones;
        cur_blank = team1_hide;
      end
      default: begin
        cur_val   = snap.s1_tens;
        cur_blank = team1_hide || (snap.s1_tens == 4'd0);
      end
    endcase
  end

  seven_seg_encoder u_encoder (
    .value (cur_val),
    .blank (cur_blank),
    .seg   (seg_next)
  );

  // The dot marks the ones digit of the team in possession.
  assign dp_next = ~(((digit_idx == DIG_S1_ONES) && !snap.possession) ||
                     ((digit_idx == DIG_S2_ONES) &&  snap.possession));

  always_ff @(posedge clock) begin
    if (reset) begin
      anode <= 4'b1111;
      seg   <= SEG_BLANK;
      dp    <= 1'b1;
    end else begin
      anode <= anode_for(digit_idx);
      seg   <= seg_next;
      dp    <= dp_next;
    end
  end

endmodule
